// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator: runtime key/IV load, warm-up, W bits/clock out.
// Optional `TRIVIUM_XOR_EN adds a din port and emits z ^ din.
module trivium_stream_gen #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int CNT_W       = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [79:0]   key,
    input  logic [79:0]   iv,
    output logic          busy,
    output logic          ks_valid,
    input  logic          ks_ready,
`ifdef TRIVIUM_XOR_EN
    input  logic [W-1:0]  din,
`endif
    output logic [W-1:0]  ks_data
);

    localparam int N = INIT_ROUNDS / W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (W < 1 || W > 64 || (W & (W - 1)) != 0) begin : g_bad_w
        $error("W must be a power of 2 in 1..64");
    end
    if (INIT_ROUNDS <= 0 || (INIT_ROUNDS % W) != 0) begin : g_bad_rounds
        $error("INIT_ROUNDS must be a positive multiple of W");
    end
    if ((longint'(1) << CNT_W) <= longint'(N)) begin : g_bad_cnt
        $error("CNT_W too narrow for INIT_ROUNDS/W");
    end

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [287:0]     s_q;
    logic [287:0]     s_step;
    logic [287:0]     s_img;
    logic [W-1:0]     z_w;
    logic [W-1:0]     word;
    logic [CNT_W-1:0] cnt_q;
    logic             init_load;
    logic             adv;
    logic             prod;

    // s_q[i-1] holds Trivium bit s_i
    always_comb begin
        logic [287:0] s;
        logic         t1;
        logic         t2;
        logic         t3;
        s   = s_q;
        z_w = '0;
        for (int j = 0; j < W; j++) begin
            t1     = s[65] ^ s[92];
            t2     = s[161] ^ s[176];
            t3     = s[242] ^ s[287];
            z_w[j] = t1 ^ t2 ^ t3;
            t1     = t1 ^ (s[90] & s[91]) ^ s[170];
            t2     = t2 ^ (s[174] & s[175]) ^ s[263];
            t3     = t3 ^ (s[285] & s[286]) ^ s[68];
            s      = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
        end
        s_step = s;
    end

    always_comb begin
        s_img          = '0;
        s_img[79:0]    = key;
        s_img[172:93]  = iv;
        s_img[287:285] = 3'b111;
    end

`ifdef TRIVIUM_XOR_EN
    assign word = z_w ^ din;
`else
    assign word = z_w;
`endif

    assign busy = (state_q == INIT);

    always_comb begin
        state_d   = state_q;
        init_load = 1'b0;
        adv       = 1'b0;
        prod      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    init_load = 1'b1;
                    state_d   = INIT;
                end
            end
            INIT: begin
                if (load) begin
                    init_load = 1'b1;
                end else begin
                    adv = 1'b1;
                    if (cnt_q == LAST) state_d = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    init_load = 1'b1;
                    state_d   = INIT;
                end else if (!ks_valid || ks_ready) begin
                    adv  = 1'b1;
                    prod = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= '0;
            cnt_q    <= '0;
            ks_valid <= 1'b0;
            ks_data  <= '0;
        end else begin
            if (init_load) begin
                s_q      <= s_img;
                cnt_q    <= '0;
                ks_valid <= 1'b0;
            end else begin
                if (adv) s_q <= s_step;
                if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
                if (prod) begin
                    ks_data  <= word;
                    ks_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_gen.sv
// Self-checking bench for trivium_stream_gen against a bit-array Trivium model.
// Covers warm-up length, streaming, backpressure, rekey and reset.
module tb_trivium_stream_gen;

    localparam int W  = 8;
    localparam int IR = 1152;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [79:0]  key;
    logic [79:0]  iv;
    logic         busy;
    logic         ks_valid;
    logic         ks_ready;
    logic [W-1:0] ks_data;
    logic [W-1:0] xor_mask;

    int vectors = 0;
    int miscompares = 0;

    bit           sm [1:288];
    logic [W-1:0] exp_cur;

    always #5 clk = ~clk;

    trivium_stream_gen #(.W(W), .INIT_ROUNDS(IR), .CNT_W(11)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .key      (key),
        .iv       (iv),
        .busy     (busy),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
`ifdef TRIVIUM_XOR_EN
        .din      (xor_mask),
`endif
        .ks_data  (ks_data)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_step(output bit z);
        bit t1, t2, t3;
        t1 = sm[66] ^ sm[93];
        t2 = sm[162] ^ sm[177];
        t3 = sm[243] ^ sm[288];
        z  = t1 ^ t2 ^ t3;
        t1 ^= (sm[91] & sm[92]) ^ sm[171];
        t2 ^= (sm[175] & sm[176]) ^ sm[264];
        t3 ^= (sm[286] & sm[287]) ^ sm[69];
        for (int i = 93; i > 1; i--) sm[i] = sm[i-1];
        sm[1] = t3;
        for (int i = 177; i > 94; i--) sm[i] = sm[i-1];
        sm[94] = t1;
        for (int i = 288; i > 178; i--) sm[i] = sm[i-1];
        sm[178] = t2;
    endtask

    task automatic ref_load(input logic [79:0] k, input logic [79:0] v);
        bit z;
        for (int i = 1; i <= 288; i++) sm[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            sm[i]      = k[i-1];
            sm[93 + i] = v[i-1];
        end
        sm[286] = 1'b1;
        sm[287] = 1'b1;
        sm[288] = 1'b1;
        repeat (IR) ref_step(z);
    endtask

    task automatic next_exp();
        bit z;
        for (int j = 0; j < W; j++) begin
            ref_step(z);
            exp_cur[j] = z;
        end
        exp_cur = exp_cur ^ xor_mask;
    endtask

    task automatic pulse_load(input logic [79:0] k, input logic [79:0] v);
        key  = k;
        iv   = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic stream(input int nwords, input bit rnd);
        int           got;
        int           cyc;
        bit           hold;
        logic [W-1:0] hold_d;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        while (got < nwords && cyc < nwords * 8 + 20) begin
            ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) begin
                check("hold_valid", 64'(ks_valid), 64'd1);
                check("hold_data", 64'(ks_data), 64'(hold_d));
            end
            if (!rnd && got > 0) check("throughput", 64'(ks_valid), 64'd1);
            if (ks_valid) begin
                check("ks_data", 64'(ks_data), 64'(exp_cur));
                if (ks_ready) begin
                    got++;
                    next_exp();
                end
            end
            hold   = ks_valid && !ks_ready;
            hold_d = ks_data;
            tick();
            cyc++;
        end
        check("stream_count", 64'(got), 64'(nwords));
    endtask

    task automatic warm(input logic [79:0] k, input logic [79:0] v);
        int n;
        ref_load(k, v);
        next_exp();
        count_busy(n);
        check("busy_cycles", 64'(n), 64'(IR / W));
        check("valid_after_busy", 64'(ks_valid), 64'd0);
    endtask

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        logic [79:0] ka, kb, kc, kd, va, vb, vc, vd;
`ifdef TRIVIUM_XOR_EN
        xor_mask = 8'hA5;
`else
        xor_mask = '0;
`endif
        rst      = 1'b1;
        load     = 1'b0;
        key      = '0;
        iv       = '0;
        ks_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(ks_valid), 64'd0);
        check("rst_data", 64'(ks_data), 64'd0);

        load = 1'b1;
        key  = rnd80();
        tick();
        rst  = 1'b0;
        load = 1'b0;
        check("load_in_rst", 64'(busy), 64'd0);
        tick();
        check("idle_after_rst", 64'(busy), 64'd0);

        // all-zero key/IV, ready held high
        ks_ready = 1'b1;
        pulse_load('0, '0);
        warm('0, '0);
        tick();
        check("first_valid", 64'(ks_valid), 64'd1);
        stream(64, 1'b0);

        // eSTREAM-style key 0x80.., IV 0, then random backpressure
        pulse_load(80'h1, '0);
        check("rekey_valid_drop", 64'(ks_valid), 64'd0);
        warm(80'h1, '0);
        stream(40, 1'b0);
        ka = rnd80();
        va = rnd80();
        pulse_load(ka, va);
        warm(ka, va);
        stream(100, 1'b1);

        // load mid-INIT restarts the warm-up
        kb = rnd80();
        vb = rnd80();
        pulse_load(kb, vb);
        repeat (50) tick();
        kc = rnd80();
        vc = rnd80();
        pulse_load(kc, vc);
        check("mid_init_busy", 64'(busy), 64'd1);
        warm(kc, vc);
        stream(20, 1'b0);

        // load mid-RUN coincident with a handshake
        check("pre_rekey_valid", 64'(ks_valid), 64'd1);
        ks_ready = 1'b1;
        kd = rnd80();
        vd = rnd80();
        pulse_load(kd, vd);
        check("mid_run_valid", 64'(ks_valid), 64'd0);
        check("mid_run_busy", 64'(busy), 64'd1);
        warm(kd, vd);
        stream(30, 1'b1);

        // reset mid-RUN, then load as from power-up
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_valid", 64'(ks_valid), 64'd0);
        check("mrst_data", 64'(ks_data), 64'd0);
        tick();
        check("mrst_idle", 64'(busy), 64'd0);
        ks_ready = 1'b1;
        pulse_load(ka, va);
        warm(ka, va);
        stream(16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
